// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Two-master to one-slave memory request arbiter. One transfer is in flight
//   at a time. The owner is registered in IDLE and its request is forwarded
//   combinationally to the slave while BUSY. Tie-breaking is round-robin on a
//   last-grant pointer.
//
// Handshake (valid/ready):
//   A master raises mX_valid with stable addr/wdata/wstrb and holds them
//   until mX_ready pulses for one cycle. The slave side sees s_valid held for
//   the whole BUSY period. s_ready completes the transfer in the same cycle,
//   and the owner sees mX_ready/mX_rdata in that cycle. s_ready is ignored
//   outside BUSY.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   m0_/m1_ valid/addr/wdata/wstrb   master requests (wstrb 0 = read)
//   m0_/m1_ ready/rdata      completion pulse and read data to each master
//   s_valid/addr/wdata/wstrb request forwarded from the granted master
//   s_ready, s_rdata         slave completion and read data
//   grant                    one-hot owner (01 = m0, 10 = m1, 00 = idle)
//   timeout_err              one-cycle pulse when a transfer is aborted
//
// Build option:
//   MEM_ARB_TIMEOUT_EN  enables the BUSY timeout counter (TIMEOUT_CYCLES).
//   Without it timeout_err is tied low and BUSY waits indefinitely.
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;   // 0 = m0, 1 = m1
  logic   last_q, last_d;     // master granted most recently (completed)

  logic busy;
  logic own_valid;
  logic done;
  logic tmo_hit;
  logic finish;
  logic [31:0] resp;

  assign busy      = (state_q == BUSY);
  assign own_valid = owner_q ? m1_valid : m0_valid;
  // An owner that withdrew its request is never completed, even if s_ready
  // happens to be high in the same cycle.
  assign done      = busy & own_valid & s_ready;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  // s_ready wins over the timeout because tmo_hit requires ~s_ready.
  assign tmo_hit = busy & own_valid & ~s_ready & (cnt_q == 8'(TIMEOUT_CYCLES));
`else
  logic tmo_unused;
  assign tmo_unused = ^TIMEOUT_CYCLES;
  assign tmo_hit    = 1'b0;
`endif

  assign finish = done | tmo_hit;
  assign resp   = done ? s_rdata : 32'hDEADBEEF;

  // Slave-side and master-side outputs, all zero whenever IDLE.
  always_comb begin
    s_valid     = busy;
    s_addr      = 32'h0;
    s_wdata     = 32'h0;
    s_wstrb     = 4'h0;
    grant       = 2'b00;
    if (busy) begin
      s_addr  = owner_q ? m1_addr  : m0_addr;
      s_wdata = owner_q ? m1_wdata : m0_wdata;
      s_wstrb = owner_q ? m1_wstrb : m0_wstrb;
      grant   = owner_q ? 2'b10 : 2'b01;
    end
    m0_ready    = finish & ~owner_q;
    m1_ready    = finish & owner_q;
    m0_rdata    = m0_ready ? resp : 32'h0;
    m1_rdata    = m1_ready ? resp : 32'h0;
    timeout_err = tmo_hit;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (m0_valid | m1_valid) begin
          state_d = BUSY;
          // Tie goes to the master that was not granted last.
          owner_d = (m0_valid & m1_valid) ? ~last_q : m1_valid;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d   = 8'h0;
`endif
        end
      end
      BUSY: begin
        if (!own_valid) begin
          // Withdrawn request: drop back without touching last-grant.
          state_d = IDLE;
        end else if (finish) begin
          state_d = IDLE;
          last_d  = owner_q;
        end else begin
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d = cnt_q + 8'h1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;   // m0 wins the first tie after reset
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q   <= 8'h0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter. Stimulus tasks push the expected slave
//   request and master response into queues; a negedge monitor pops and
//   compares whenever the DUT starts a slave request or pulses a ready.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_valid = 1'b0, m1_valid = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready = 1'b0;
  logic [31:0] s_rdata = '0;
  logic [1:0]  grant;
  logic        timeout_err;

  int checks   = 0;
  int failures = 0;

  // {owner_is_m1, timeout, rdata}
  logic [33:0] exp_rdy_q[$];
  // {grant, addr, wdata, wstrb}
  logic [69:0] exp_slv_q[$];

  // Slave model configuration.
  int          slv_lat   = 0;    // s_ready in BUSY cycle slv_lat+1
  bit          slv_never = 1'b1;
  bit          slv_noise = 1'b0; // drive s_ready high while idle
  logic [31:0] slv_data  = '0;
  int          scnt      = 0;

  mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- slave model ----------------
  always @(posedge clk) begin
    #1;
    if (s_valid) scnt++;
    else         scnt = 0;
    s_ready = s_valid ? (!slv_never && scnt > slv_lat) : slv_noise;
    s_rdata = s_ready ? slv_data : 32'h0;
  end

  // ---------------- monitor / scoreboard ----------------
  logic        sv_prev = 1'b0;
  logic [33:0] e_rdy;
  logic [69:0] e_slv;

  always @(negedge clk) begin
    if (rst) begin
      sv_prev = 1'b0;
    end else begin
      if (m0_ready || m1_ready) begin
        if (exp_rdy_q.size() == 0) begin
          check("unexpected_ready", {68'h0, m1_ready, m0_ready}, 70'h0);
        end else begin
          e_rdy = exp_rdy_q.pop_front();
          check("ready_resp",
                {35'h0, m1_ready, m0_ready, timeout_err, (m1_ready ? m1_rdata : m0_rdata)},
                {35'h0, e_rdy[33], ~e_rdy[33], e_rdy[32], e_rdy[31:0]});
        end
      end
      check("rdata_gate", {6'h0, (m0_ready ? 32'h0 : m0_rdata), (m1_ready ? 32'h0 : m1_rdata)}, 70'h0);
      if (s_valid && !sv_prev) begin
        if (exp_slv_q.size() == 0) begin
          check("unexpected_slave_req", {68'h0, grant}, 70'h0);
        end else begin
          e_slv = exp_slv_q.pop_front();
          check("slave_req", {grant, s_addr, s_wdata, s_wstrb}, e_slv);
        end
      end
      if (!s_valid)
        check("idle_outputs", {grant, s_addr, s_wdata, s_wstrb, m0_ready, m1_ready, timeout_err}, 70'h0);
      sv_prev = s_valid;
    end
  end

  // ---------------- master driver ----------------
  // Raises valid, waits (bounded) for ready, then drops valid. lat counts
  // negedges after issue: 0 is the IDLE cycle, 1 the first BUSY cycle.
  task automatic m_req(input bit m, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] st, input int max_cyc, output int lat);
    @(posedge clk); #1;
    if (!m) begin m0_valid = 1'b1; m0_addr = a; m0_wdata = d; m0_wstrb = st; end
    else    begin m1_valid = 1'b1; m1_addr = a; m1_wdata = d; m1_wstrb = st; end
    lat = -1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if ((m ? m1_ready : m0_ready) === 1'b1) begin
        lat = i;
        break;
      end
    end
    @(posedge clk); #1;
    if (!m) begin m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0; end
    else    begin m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0; end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog simulation did not complete in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  int lat0, lat1;

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_outputs",
          {s_valid, s_addr, s_wdata, s_wstrb, m0_ready, m1_ready, grant, timeout_err},
          70'h0);
    check("reset_rdata", {6'h0, m0_rdata, m1_rdata}, 70'h0);
    @(posedge clk); #1 rst = 1'b0;

    // m0 read of 0x100, slave answers 2 cycles after s_valid.
    @(negedge clk);
    slv_never = 1'b0; slv_lat = 2; slv_data = 32'h12345678;
    exp_slv_q.push_back({2'b01, 32'h100, 32'h0, 4'h0});
    exp_rdy_q.push_back({1'b0, 1'b0, 32'h12345678});
    fork
      m_req(1'b0, 32'h100, 32'h0, 4'h0, 50, lat0);
      begin
        @(posedge clk); #1;
        @(negedge clk);
        check("latency_pre", {67'h0, s_valid, grant}, 70'h0);
        @(negedge clk);
        check("latency_post", {67'h0, s_valid, grant}, {67'h0, 1'b1, 2'b01});
      end
    join
    check("t1_lat", lat0, 3);
    @(negedge clk);
    check("grant_idle", {68'h0, grant}, 70'h0);

    // m1 byte write; s_ready noise while idle must be ignored from here on.
    slv_noise = 1'b1; slv_lat = 0; slv_data = 32'h5A5A0000;
    repeat (4) @(negedge clk);
    exp_slv_q.push_back({2'b10, 32'h02000000, 32'h020000AA, 4'b0001});
    exp_rdy_q.push_back({1'b1, 1'b0, 32'h5A5A0000});
    m_req(1'b1, 32'h02000000, 32'h020000AA, 4'b0001, 50, lat1);
    check("t2_lat", lat1, 1);

    // Tie with last-grant = m1: m0 first, m1 after one IDLE gap.
    @(negedge clk);
    slv_lat = 1; slv_data = 32'hCAFE0001;
    exp_slv_q.push_back({2'b01, 32'h200, 32'h11111111, 4'hF});
    exp_slv_q.push_back({2'b10, 32'h300, 32'h0, 4'h0});
    exp_rdy_q.push_back({1'b0, 1'b0, 32'hCAFE0001});
    exp_rdy_q.push_back({1'b1, 1'b0, 32'hCAFE0001});
    fork
      m_req(1'b0, 32'h200, 32'h11111111, 4'hF, 50, lat0);
      m_req(1'b1, 32'h300, 32'h0, 4'h0, 50, lat1);
    join
    check("tie1_m0_lat", lat0, 2);
    check("tie1_m1_lat", lat1, 5);

    // Single m0 leaves last-grant = m0, so the next tie goes m1 then m0.
    @(negedge clk);
    slv_lat = 0; slv_data = 32'h00000042;
    exp_slv_q.push_back({2'b01, 32'h400, 32'h0, 4'h0});
    exp_rdy_q.push_back({1'b0, 1'b0, 32'h00000042});
    m_req(1'b0, 32'h400, 32'h0, 4'h0, 50, lat0);
    @(negedge clk);
    exp_slv_q.push_back({2'b10, 32'h500, 32'h0, 4'h0});
    exp_slv_q.push_back({2'b01, 32'h600, 32'h0, 4'h0});
    exp_rdy_q.push_back({1'b1, 1'b0, 32'h00000042});
    exp_rdy_q.push_back({1'b0, 1'b0, 32'h00000042});
    fork
      m_req(1'b0, 32'h600, 32'h0, 4'h0, 50, lat0);
      m_req(1'b1, 32'h500, 32'h0, 4'h0, 50, lat1);
    join
    check("tie2_m1_lat", lat1, 1);
    check("tie2_m0_lat", lat0, 3);

    // m1 withdraws mid-BUSY: no ready, last-grant stays m0.
    @(negedge clk);
    slv_never = 1'b1;
    exp_slv_q.push_back({2'b10, 32'h700, 32'h0, 4'h0});
    @(posedge clk); #1;
    m1_valid = 1'b1; m1_addr = 32'h700;
    repeat (3) @(posedge clk);
    #1 m1_valid = 1'b0; m1_addr = '0;
    @(posedge clk);
    @(negedge clk);
    check("abort_idle", {66'h0, s_valid, grant, m1_ready}, 70'h0);
    slv_never = 1'b0; slv_lat = 0; slv_data = 32'h0000BEE5;
    exp_slv_q.push_back({2'b10, 32'h800, 32'h0, 4'h0});
    exp_slv_q.push_back({2'b01, 32'h900, 32'h0, 4'h0});
    exp_rdy_q.push_back({1'b1, 1'b0, 32'h0000BEE5});
    exp_rdy_q.push_back({1'b0, 1'b0, 32'h0000BEE5});
    fork
      m_req(1'b0, 32'h900, 32'h0, 4'h0, 50, lat0);
      m_req(1'b1, 32'h800, 32'h0, 4'h0, 50, lat1);
    join
    check("abort_tie_m1_lat", lat1, 1);
    check("abort_tie_m0_lat", lat0, 3);

    // Reset mid-BUSY with last-grant = m0; after reset the tie goes to m0.
    @(negedge clk);
    slv_never = 1'b1;
    exp_slv_q.push_back({2'b10, 32'hA00, 32'h0, 4'h0});
    @(posedge clk); #1;
    m1_valid = 1'b1; m1_addr = 32'hA00;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1 check("reset_async", {65'h0, s_valid, grant, m0_ready, m1_ready, timeout_err}, 70'h0);
    m1_valid = 1'b0; m1_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    slv_never = 1'b0; slv_lat = 0; slv_data = 32'h00C0FFEE;
    exp_slv_q.push_back({2'b01, 32'hB00, 32'h0, 4'h0});
    exp_slv_q.push_back({2'b10, 32'hC00, 32'h0, 4'h0});
    exp_rdy_q.push_back({1'b0, 1'b0, 32'h00C0FFEE});
    exp_rdy_q.push_back({1'b1, 1'b0, 32'h00C0FFEE});
    fork
      m_req(1'b0, 32'hB00, 32'h0, 4'h0, 50, lat0);
      m_req(1'b1, 32'hC00, 32'h0, 4'h0, 50, lat1);
    join
    check("rst_tie_m0_lat", lat0, 1);
    check("rst_tie_m1_lat", lat1, 3);

    // Slave never answers.
    @(negedge clk);
    slv_never = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
    exp_slv_q.push_back({2'b01, 32'hD00, 32'h0, 4'h0});
    exp_rdy_q.push_back({1'b0, 1'b1, 32'hDEADBEEF});
    m_req(1'b0, 32'hD00, 32'h0, 4'h0, 50, lat0);
    check("timeout_lat", lat0, 5);
    // s_ready in the same cycle as the timeout: the slave wins.
    @(negedge clk);
    slv_never = 1'b0; slv_lat = 4; slv_data = 32'h600DDA7A;
    exp_slv_q.push_back({2'b10, 32'hE00, 32'h0, 4'h0});
    exp_rdy_q.push_back({1'b1, 1'b0, 32'h600DDA7A});
    m_req(1'b1, 32'hE00, 32'h0, 4'h0, 50, lat1);
    check("timeout_prio_lat", lat1, 5);
`else
    exp_slv_q.push_back({2'b01, 32'hD00, 32'h0, 4'h0});
    m_req(1'b0, 32'hD00, 32'h0, 4'h0, 1000, lat0);
    check("no_timeout", lat0, -1);
`endif

    repeat (3) @(negedge clk);
    check("slave_queue_empty", exp_slv_q.size(), 0);
    check("ready_queue_empty", exp_rdy_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
